axi_ram_slave: RTL and testbench
================================

Name: axi_ram_slave

Overview:
- AXI4 slave memory: the responder end of the AXI master interface that the cache-bus bridge drives.
- Accepts one AR or AW burst at a time and serves it from an internal 64-bit-wide RAM.
- Used as the memory model behind the bridge in simulation and in FPGA bring-up.
- Supports FIXED, INCR and WRAP bursts, byte strobes and DECERR for out-of-range addresses.

Parameters:
- MEM_WORDS, 4096, number of 64-bit words; memory spans bytes 0 .. MEM_WORDS*8-1.
- BASE_ADDR, 64'h0, byte address of word 0.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous, active-low reset.
- AR channel: arid in 4, araddr in 64, arlen in 8, arsize in 3, arburst in 2, arlock in 1, arcache in 4, arprot in 3, arvalid in 1, arready out 1.
- R channel: rid out 4, rdata out 64, rresp out 2, rlast out 1, rvalid out 1, rready in 1.
- AW channel: awid in 4, awaddr in 64, awlen in 8, awsize in 3, awburst in 2, awlock in 1, awcache in 4, awprot in 3, awvalid in 1, awready out 1.
- W channel: wdata in 64, wstrb in 8, wlast in 1, wvalid in 1, wready out 1.
- B channel: bid out 4, bresp out 2, bvalid out 1, bready in 1.
- arlock, arcache, arprot, awlock, awcache, awprot: accepted and ignored.

Behaviour:
- Reset (areset=0, async): state=IDLE; all ready/valid outputs 0; rid, rdata, rresp, rlast, bid, bresp = 0. RAM contents are not reset.
- FSM states: IDLE, RD, WR, WRESP.
- IDLE, accepting a request:
  - arready=1 in IDLE.
  - awready=1 in IDLE only when arvalid=0, so a read wins over a simultaneous write.
  - On the handshake, latch id, addr, len, size and burst; set beat counter=0; move to RD or WR.
- RD:
  - rvalid=1 starting the cycle after the AR handshake, so the first beat has one cycle of latency.
  - rdata = full 64-bit word at cur_addr[..:3]; rid = latched arid; rlast = (beat==len).
  - Outputs hold stable while rready=0.
  - On rvalid&&rready: advance the address and beat counter. If rlast, go to IDLE; rvalid drops the next cycle.
- WR:
  - wready=1.
  - On wvalid: write each byte lane i where wstrb[i]=1; advance the address and beat counter.
  - After beat len is accepted, go to WRESP. wlast is not used for counting.
  - If wlast != (beat==len) on any beat, the final bresp is SLVERR (2'b10).
- WRESP: bvalid=1, bid = latched awid, bresp = OKAY, SLVERR or DECERR. On bready, go to IDLE.
- Address advance, with incr = 1<<size (size>3 is treated as 3):
  - FIXED (2'b00): address unchanged.
  - INCR (2'b01): addr += incr, 64-bit wrap-around.
  - WRAP (2'b10): container = (len+1)*incr. next = (addr & ~(container-1)) | ((addr+incr) & (container-1)). The bench uses len in {1,3,7,15}.
  - 2'b11 is treated as INCR.
- Range check, per beat: word index = (addr-BASE_ADDR)>>3.
  - Index >= MEM_WORDS or addr < BASE_ADDR: reads return rdata=0 with rresp=DECERR (2'b11); writes are dropped and bresp=DECERR.
  - DECERR takes precedence over SLVERR.
  - Otherwise rresp=OKAY.
- Narrow transfers: the slave does not shift data. The master places bytes on the correct lanes and wstrb selects them.
- Single outstanding transaction: arready and awready are 0 outside IDLE.
- Reset mid-burst: the FSM returns to IDLE immediately. Bytes already written stay written and the rest of the burst is discarded.

Test Plan:
- Write 1 beat at 0x40, data 64'h1122334455667788, wstrb 8'hFF, awlen 0, INCR -> bvalid with bresp=0, bid=awid. A following read of 0x40 -> rdata 64'h1122334455667788, rlast=1, rvalid exactly 1 cycle after the AR handshake.
- INCR write of 4 beats at 0x100 with data 1,2,3,4; then a WRAP read at 0x110, arlen 3, size 3 -> beats 3,4,1,2 (addresses 0x110, 0x118, 0x100, 0x108); rlast only on beat 4.
- Partial strobe: pre-write 64'hFFFF_FFFF_FFFF_FFFF at 0x0, then write 64'h0 with wstrb 8'h0F -> read returns 64'hFFFF_FFFF_0000_0000.
- arvalid and awvalid asserted in the same cycle in IDLE -> arready=1 and awready=0. The read completes first, then awready=1 in IDLE.
- rready held low for 3 cycles during a burst -> rvalid, rdata and rlast stay stable and no beat is skipped. Read at MEM_WORDS*8 -> rresp=2'b11 and rdata=0. A 2-beat write with wlast on beat 1 -> bresp=2'b10.
- Assert areset=0 mid-way through a 4-beat write, after 2 beats -> on the same edge all valid/ready outputs are 0. After release the slave accepts a new AR, and the first 2 beats are readable.

Source files
------------

// File: rtl/axi_ram_slave_if.sv
// rtl/axi_ram_slave_if.sv - AXI4 channel bundle between a bus master and axi_ram_slave
//
// Purpose: groups the five AXI4 channels (AR, R, AW, W, B) with 4-bit ids,
// 64-bit addresses and 64-bit data into one port.
// Ports (modports):
//   master - drives AR/AW/W requests plus rready/bready, receives R and B.
//   slave  - receives AR/AW/W requests plus rready/bready, drives R and B.
interface axi_ram_slave_if;
  logic [3:0]  arid;
  logic [63:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [63:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_ram_slave.sv
// rtl/axi_ram_slave.sv - AXI4 slave memory serving one burst at a time from a 64-bit RAM
//
// Purpose: responder end of an AXI4 master port. Accepts a single AR or AW
// burst (read wins a tie), supports FIXED/INCR/WRAP bursts, byte strobes,
// SLVERR on wlast misplacement and DECERR outside BASE_ADDR .. BASE_ADDR+MEM_WORDS*8-1.
// Ports:
//   aclk   - clock
//   areset - asynchronous active-low reset (RAM contents are kept)
//   bus    - axi_ram_slave_if.slave, all five AXI4 channels
module axi_ram_slave #(
  parameter int unsigned MEM_WORDS = 4096,
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic           aclk,
  input  logic           areset,
  axi_ram_slave_if.slave bus
);
  localparam int unsigned IDX_W       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;
  state_t state, state_nxt;

  logic [63:0] mem [MEM_WORDS];

  logic [3:0]  cur_id;
  logic [63:0] cur_addr;
  logic [7:0]  cur_len;
  logic [1:0]  cur_size;   // already clamped to 0..3
  logic [1:0]  cur_burst;
  logic [7:0]  beat;
  logic        err_dec;
  logic        err_slv;

  function automatic logic in_range(input logic [63:0] a);
    logic [63:0] word;
    word = (a - BASE_ADDR) >> 3;
    return (a >= BASE_ADDR) && (word < 64'(MEM_WORDS));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [63:0] a);
    logic [63:0] word;
    word = (a - BASE_ADDR) >> 3;
    return word[IDX_W-1:0];
  endfunction

  function automatic logic [1:0] clamp_size(input logic [2:0] s);
    return (s > 3'd3) ? 2'd3 : s[1:0];
  endfunction

  // WRAP keeps the upper address bits fixed and lets the low bits roll over
  // inside a (len+1)*incr container; 2'b11 falls through to INCR.
  function automatic logic [63:0] next_addr(input logic [63:0] a, input logic [7:0] len,
                                            input logic [1:0] sz, input logic [1:0] burst);
    logic [63:0] incr, mask, res;
    incr = 64'd1 << sz;
    mask = ((64'(len) + 64'd1) << sz) - 64'd1;
    case (burst)
      2'b00:   res = a;
      2'b10:   res = (a & ~mask) | ((a + incr) & mask);
      default: res = a + incr;
    endcase
    return res;
  endfunction

  logic        last_beat;
  logic [63:0] addr_nxt;
  logic [63:0] rd_addr;
  logic        rd_ok;
  logic        wr_dec;
  logic        wr_slv;
  logic        unused_ok;

  assign last_beat = (beat == cur_len);
  assign addr_nxt  = next_addr(cur_addr, cur_len, cur_size, cur_burst);
  // A beat's read data is fetched on the edge that opens it: the AR handshake
  // for beat 0, the previous R handshake for the others.
  assign rd_addr   = (state == IDLE) ? bus.araddr : addr_nxt;
  assign rd_ok     = in_range(rd_addr);
  assign wr_dec    = err_dec | ~in_range(cur_addr);
  assign wr_slv    = err_slv | (bus.wlast != last_beat);
  assign unused_ok = ^{bus.arlock, bus.arcache, bus.arprot,
                       bus.awlock, bus.awcache, bus.awprot};

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Handshake outputs are gated by areset so they read 0 while reset is held.
  always_comb begin
    state_nxt   = state;
    bus.arready = 1'b0;
    bus.awready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    case (state)
      IDLE: begin
        bus.arready = areset;
        bus.awready = areset & ~bus.arvalid;
        if (bus.arvalid)      state_nxt = RD;
        else if (bus.awvalid) state_nxt = WR;
      end
      RD: begin
        bus.rvalid = areset;
        if (bus.rready && bus.rlast) state_nxt = IDLE;
      end
      WR: begin
        bus.wready = areset;
        if (bus.wvalid && last_beat) state_nxt = WRESP;
      end
      WRESP: begin
        bus.bvalid = areset;
        if (bus.bready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      cur_id    <= '0;
      cur_addr  <= '0;
      cur_len   <= '0;
      cur_size  <= '0;
      cur_burst <= '0;
      beat      <= '0;
      err_dec   <= 1'b0;
      err_slv   <= 1'b0;
      bus.rid   <= '0;
      bus.rdata <= '0;
      bus.rresp <= '0;
      bus.rlast <= 1'b0;
      bus.bid   <= '0;
      bus.bresp <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.arvalid) begin
            cur_id    <= bus.arid;
            cur_addr  <= bus.araddr;
            cur_len   <= bus.arlen;
            cur_size  <= clamp_size(bus.arsize);
            cur_burst <= bus.arburst;
            beat      <= '0;
            bus.rid   <= bus.arid;
            bus.rlast <= (bus.arlen == 8'd0);
            bus.rdata <= rd_ok ? mem[word_idx(rd_addr)] : '0;
            bus.rresp <= rd_ok ? RESP_OKAY : RESP_DECERR;
          end else if (bus.awvalid) begin
            cur_id    <= bus.awid;
            cur_addr  <= bus.awaddr;
            cur_len   <= bus.awlen;
            cur_size  <= clamp_size(bus.awsize);
            cur_burst <= bus.awburst;
            beat      <= '0;
            err_dec   <= 1'b0;
            err_slv   <= 1'b0;
          end
        end
        RD: begin
          if (bus.rready) begin
            cur_addr  <= addr_nxt;
            beat      <= beat + 8'd1;
            bus.rlast <= ((beat + 8'd1) == cur_len);
            bus.rdata <= rd_ok ? mem[word_idx(rd_addr)] : '0;
            bus.rresp <= rd_ok ? RESP_OKAY : RESP_DECERR;
          end
        end
        WR: begin
          if (bus.wvalid) begin
            cur_addr <= addr_nxt;
            beat     <= beat + 8'd1;
            err_dec  <= wr_dec;
            err_slv  <= wr_slv;
            if (last_beat) begin
              bus.bid   <= cur_id;
              bus.bresp <= wr_dec ? RESP_DECERR : (wr_slv ? RESP_SLVERR : RESP_OKAY);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // RAM write port, no reset so contents survive areset.
  always_ff @(posedge aclk) begin
    if (areset && state == WR && bus.wvalid && in_range(cur_addr)) begin
      for (int i = 0; i < 8; i++) begin
        if (bus.wstrb[i]) mem[word_idx(cur_addr)][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi_ram_slave.sv
// tb/tb_axi_ram_slave.sv - self-checking randomized bench for axi_ram_slave
module tb_axi_ram_slave;
  localparam int unsigned MEM_WORDS = 256;
  localparam logic [63:0] BASE_ADDR = 64'h0;

  logic aclk;
  logic areset;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  axi_ram_slave_if bus ();

  axi_ram_slave #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE_ADDR)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  logic [63:0] ref_mem [MEM_WORDS];
  logic [63:0] wd [256];
  logic [7:0]  ws [256];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic ref_ok(input logic [63:0] a);
    return (a >= BASE_ADDR) && (((a - BASE_ADDR) >> 3) < 64'(MEM_WORDS));
  endfunction

  function automatic int ref_idx(input logic [63:0] a);
    return int'((a - BASE_ADDR) >> 3);
  endfunction

  // Byte address of beat i of a burst.
  function automatic logic [63:0] ref_addr(input logic [63:0] start, input int len,
                                           input int size, input int burst, input int i);
    logic [63:0] incr, cont, low;
    incr = 64'd1 << ((size > 3) ? 3 : size);
    case (burst)
      0: return start;
      2: begin
        cont = 64'(len + 1) * incr;
        low  = start - (start % cont);
        return low + ((start - low + 64'(i) * incr) % cont);
      end
      default: return start + 64'(i) * incr;
    endcase
  endfunction

  task automatic idle_inputs();
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.arlock = 1'b0; bus.arcache = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awlock = 1'b0; bus.awcache = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
  endtask

  // Write burst using wd/ws; wlast is driven on beat last_at. abort_after >= 0
  // pulls areset while that beat is presented and returns.
  task automatic axi_write(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input int last_at,
                           input bit skip_aw, input int abort_after);
    int t;
    logic [63:0] a;
    bit dec, slv;
    dec = 0; slv = 0;
    if (!skip_aw) begin
      @(negedge aclk);
      bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
      bus.awlock = 1'($urandom); bus.awcache = 4'($urandom); bus.awprot = 3'($urandom);
      bus.awvalid = 1'b1;
      t = 0; #1;
      while (!bus.awready && t < 50) begin @(negedge aclk); #1; t++; end
      check("aw_accept", bus.awready, 1);
      @(posedge aclk);
    end
    for (int i = 0; i <= int'(len); i++) begin
      @(negedge aclk);
      bus.awvalid = 1'b0;
      if ($urandom_range(0, 3) == 0) begin bus.wvalid = 1'b0; @(negedge aclk); end
      bus.wvalid = 1'b1; bus.wdata = wd[i]; bus.wstrb = ws[i]; bus.wlast = (i == last_at);
      if (abort_after == i) begin
        areset = 1'b0; #1;
        check("rst_arready", bus.arready, 0);
        check("rst_awready", bus.awready, 0);
        check("rst_wready",  bus.wready,  0);
        check("rst_rvalid",  bus.rvalid,  0);
        check("rst_bvalid",  bus.bvalid,  0);
        @(negedge aclk); idle_inputs();
        @(negedge aclk); areset = 1'b1;
        return;
      end
      t = 0; #1;
      while (!bus.wready && t < 50) begin @(negedge aclk); #1; t++; end
      check("w_ready", bus.wready, 1);
      a = ref_addr(addr, int'(len), int'(size), int'(burst), i);
      if (ref_ok(a)) begin
        for (int b = 0; b < 8; b++)
          if (ws[i][b]) ref_mem[ref_idx(a)][8*b +: 8] = wd[i][8*b +: 8];
      end else dec = 1;
      if ((i == last_at) != (i == int'(len))) slv = 1;
      @(posedge aclk);
    end
    @(negedge aclk);
    bus.wvalid = 1'b0; bus.wlast = 1'b0; #1;
    check("b_valid", bus.bvalid, 1);
    repeat ($urandom_range(0, 2)) @(negedge aclk);
    bus.bready = 1'b1; #1;
    check("b_id", bus.bid, id);
    check("b_resp", bus.bresp, dec ? 2'b11 : (slv ? 2'b10 : 2'b00));
    @(posedge aclk);
    @(negedge aclk);
    bus.bready = 1'b0; #1;
    check("b_drop", bus.bvalid, 0);
  endtask

  // stall_mode: 0 random rready, 1 always ready, 2 rready low 3 cycles on beat 1.
  task automatic axi_read(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input int stall_mode,
                          input bit skip_ar);
    int t, beat, cyc, stalls;
    logic [63:0] a;
    bit ok;
    if (!skip_ar) begin
      @(negedge aclk);
      bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
      bus.arlock = 1'($urandom); bus.arcache = 4'($urandom); bus.arprot = 3'($urandom);
      bus.arvalid = 1'b1;
      t = 0; #1;
      while (!bus.arready && t < 50) begin @(negedge aclk); #1; t++; end
      check("ar_accept", bus.arready, 1);
      check("r_pre", bus.rvalid, 0);
      @(posedge aclk);
    end
    @(negedge aclk);
    bus.arvalid = 1'b0; #1;
    check("r_latency", bus.rvalid, 1);
    beat = 0; cyc = 0; stalls = 0;
    while (beat <= int'(len) && cyc < 2000) begin
      case (stall_mode)
        0:       bus.rready = ($urandom_range(0, 3) != 0);
        2:       bus.rready = !(beat == 1 && stalls < 3);
        default: bus.rready = 1'b1;
      endcase
      if (!bus.rready) stalls++;
      a  = ref_addr(addr, int'(len), int'(size), int'(burst), beat);
      ok = ref_ok(a);
      check("r_valid", bus.rvalid, 1);
      check("r_id",    bus.rid, id);
      check("r_data",  bus.rdata, ok ? ref_mem[ref_idx(a)] : 64'h0);
      check("r_resp",  bus.rresp, ok ? 2'b00 : 2'b11);
      check("r_last",  bus.rlast, beat == int'(len));
      if (bus.rready) beat++;
      @(negedge aclk); #1;
      cyc++;
    end
    check("r_beats", 64'(beat), 64'(int'(len) + 1));
    bus.rready = 1'b0;
    check("r_drop", bus.rvalid, 0);
  endtask

  initial begin
    logic [7:0] len;
    logic [1:0] burst;
    int lens [4] = '{1, 3, 7, 15};

    idle_inputs();
    areset = 1'b0;
    repeat (3) @(negedge aclk);
    #1;
    check("rst_arready", bus.arready, 0);
    check("rst_awready", bus.awready, 0);
    check("rst_rvalid",  bus.rvalid,  0);
    check("rst_wready",  bus.wready,  0);
    check("rst_bvalid",  bus.bvalid,  0);
    check("rst_rid",     bus.rid,     0);
    check("rst_rdata",   bus.rdata,   0);
    check("rst_rresp",   bus.rresp,   0);
    check("rst_rlast",   bus.rlast,   0);
    check("rst_bid",     bus.bid,     0);
    check("rst_bresp",   bus.bresp,   0);
    @(negedge aclk);
    areset = 1'b1;

    for (int i = 0; i < 256; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    axi_write(64'h0, 8'd255, 3'd3, 2'b01, 4'h0, 255, 0, -1);

    wd[0] = 64'h1122334455667788; ws[0] = 8'hFF;
    axi_write(64'h40, 8'd0, 3'd3, 2'b01, 4'h5, 0, 0, -1);
    axi_read(64'h40, 8'd0, 3'd3, 2'b01, 4'h6, 1, 0);

    for (int i = 0; i < 4; i++) begin wd[i] = 64'(i + 1); ws[i] = 8'hFF; end
    axi_write(64'h100, 8'd3, 3'd3, 2'b01, 4'h1, 3, 0, -1);
    axi_read(64'h110, 8'd3, 3'd3, 2'b10, 4'h2, 1, 0);

    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
    axi_write(64'h0, 8'd0, 3'd3, 2'b01, 4'h3, 0, 0, -1);
    wd[0] = 64'h0; ws[0] = 8'h0F;
    axi_write(64'h0, 8'd0, 3'd3, 2'b01, 4'h3, 0, 0, -1);
    axi_read(64'h0, 8'd0, 3'd3, 2'b01, 4'h4, 1, 0);

    // Simultaneous AR and AW: the read goes first.
    @(negedge aclk);
    bus.arid = 4'h7; bus.araddr = 64'h40; bus.arlen = 8'd0; bus.arsize = 3'd3; bus.arburst = 2'b01;
    bus.arvalid = 1'b1;
    bus.awid = 4'h8; bus.awaddr = 64'h48; bus.awlen = 8'd0; bus.awsize = 3'd3; bus.awburst = 2'b01;
    bus.awvalid = 1'b1;
    #1;
    check("tie_arready", bus.arready, 1);
    check("tie_awready", bus.awready, 0);
    @(posedge aclk);
    axi_read(64'h40, 8'd0, 3'd3, 2'b01, 4'h7, 1, 1);
    check("tie_aw_after", bus.awready, 1);
    @(posedge aclk);
    wd[0] = 64'hCAFE_F00D_1234_5678; ws[0] = 8'hFF;
    axi_write(64'h48, 8'd0, 3'd3, 2'b01, 4'h8, 0, 1, -1);
    axi_read(64'h48, 8'd0, 3'd3, 2'b01, 4'h9, 1, 0);

    axi_read(64'h100, 8'd3, 3'd3, 2'b01, 4'hA, 2, 0);
    axi_read(64'(MEM_WORDS * 8), 8'd0, 3'd3, 2'b01, 4'hB, 1, 0);

    for (int i = 0; i < 2; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    axi_write(64'h200, 8'd1, 3'd3, 2'b01, 4'hC, 0, 0, -1);
    axi_write(64'(MEM_WORDS * 8 - 8), 8'd1, 3'd3, 2'b01, 4'hD, 1, 0, -1);
    axi_read(64'(MEM_WORDS * 8 - 8), 8'd1, 3'd3, 2'b01, 4'hD, 1, 0);

    for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    axi_write(64'h300, 8'd3, 3'd3, 2'b01, 4'hE, 3, 0, 2);
    axi_read(64'h300, 8'd3, 3'd3, 2'b01, 4'hF, 0, 0);

    for (int n = 0; n < 60; n++) begin
      burst = 2'($urandom_range(0, 3));
      len   = (burst == 2'b10) ? 8'(lens[$urandom_range(0, 3)]) : 8'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i <= int'(len); i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
        axi_write(64'($urandom_range(0, MEM_WORDS * 8 + 127)), len, 3'($urandom_range(0, 4)), burst,
                  4'($urandom), int'(len), 0, -1);
      end else begin
        axi_read(64'($urandom_range(0, MEM_WORDS * 8 + 127)), len, 3'($urandom_range(0, 4)), burst,
                 4'($urandom), 0, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
